// File: rtl/filter_sum_clip.sv
// Four-tap product summation, rounding, normalisation shift and pixel clip.
// Two-stage valid/ready pipeline with a per-block sample counter driving out_last.
module filter_sum_clip #(
   parameter int PROD_W      = 16,
   parameter int OUT_W       = 8,
   parameter int SHIFT       = 6,
   parameter int ROUND       = 32,
   parameter int BLK_SAMPLES = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [PROD_W-1:0] p0,
   input  logic signed [PROD_W-1:0] p1,
   input  logic signed [PROD_W-1:0] p2,
   input  logic signed [PROD_W-1:0] p3,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_W-1:0]         out_pix,
   output logic                     out_last,
   output logic                     clip_flag
);

   localparam int IDX_W = (BLK_SAMPLES > 1) ? $clog2(BLK_SAMPLES) : 1;
   localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(BLK_SAMPLES - 1);
   localparam logic signed [PROD_W+1:0] ROUND_C  = (PROD_W+2)'(ROUND);
   localparam logic [OUT_W-1:0]         PIX_MAX  = {OUT_W{1'b1}};

   logic                     ready_en_r;
   logic                     s1_valid_r;
   logic signed [PROD_W:0]   s1_a_r;
   logic signed [PROD_W:0]   s1_b_r;
   logic [IDX_W-1:0]         idx_r;

   logic                     s2_load_s;
   logic                     in_xfer_s;
   logic                     out_xfer_s;
   logic signed [PROD_W+1:0] sum_s;
   logic signed [PROD_W+1:0] v_s;
   logic [OUT_W-1:0]         pix_next_s;
   logic                     clip_next_s;

   // Handshake qualifiers; S1 may accept whenever it is empty or draining into S2.
   always_comb begin
      s2_load_s  = ~out_valid | out_ready;
      in_ready   = ready_en_r & (~s1_valid_r | s2_load_s);
      in_xfer_s  = in_valid & in_ready;
      out_xfer_s = out_valid & out_ready;
      out_last   = out_valid & (idx_r == IDX_LAST);
   end

   // Final sum, floor shift and clip to the pixel range.
   always_comb begin
      sum_s       = {s1_a_r[PROD_W], s1_a_r} + {s1_b_r[PROD_W], s1_b_r} + ROUND_C;
      v_s         = sum_s >>> SHIFT;
      pix_next_s  = v_s[OUT_W-1:0];
      clip_next_s = 1'b0;
      if (v_s[PROD_W+1]) begin
         pix_next_s  = {OUT_W{1'b0}};
         clip_next_s = 1'b1;
      end else if (|v_s[PROD_W:OUT_W]) begin
         pix_next_s  = PIX_MAX;
         clip_next_s = 1'b1;
      end else begin
         pix_next_s  = v_s[OUT_W-1:0];
         clip_next_s = 1'b0;
      end
   end

   // in_ready is held low for the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
      end
   end

   // Stage 1: pairwise sums of sign-extended products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= '0;
         s1_b_r     <= '0;
      end else if (in_xfer_s) begin
         s1_valid_r <= 1'b1;
         s1_a_r     <= {p0[PROD_W-1], p0} + {p1[PROD_W-1], p1};
         s1_b_r     <= {p2[PROD_W-1], p2} + {p3[PROD_W-1], p3};
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: output registers, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_pix   <= '0;
         clip_flag <= 1'b0;
      end else if (s2_load_s) begin
         out_valid <= s1_valid_r;
         if (s1_valid_r) begin
            out_pix   <= pix_next_s;
            clip_flag <= clip_next_s;
         end
      end
   end

   // Position of the current output sample within its block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= '0;
      end else if (out_xfer_s) begin
         idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + 1'b1;
      end
   end

endmodule

// File: tb/tb_filter_sum_clip.sv
// Directed bench for filter_sum_clip: arithmetic, rounding, clipping, stalls,
// block marker and mid-block reset, with hand-computed expectations.
module tb_filter_sum_clip;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] p0, p1, p2, p3;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_pix;
   logic               out_last;
   logic               clip_flag;

   int checks   = 0;
   int failures = 0;

   filter_sum_clip dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3),
      .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
      .out_last(out_last), .clip_flag(clip_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_one(input logic signed [15:0] a, input logic signed [15:0] b,
                           input logic signed [15:0] c, input logic signed [15:0] d,
                           input logic [7:0] ep, input logic ec, input string tag);
      step();
      p0 = a; p1 = b; p2 = c; p3 = d;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk({tag, " in_ready"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      chk({tag, " valid_c1"}, out_valid, 0);
      step();
      chk({tag, " valid_c2"}, out_valid, 1);
      chk({tag, " pix"}, out_pix, ep);
      chk({tag, " clip"}, clip_flag, ec);
   endtask

   // Continuous flow of n samples; sample k is expected to come out as (k*7)%256.
   task automatic stream(input int n, input string tag);
      int  sent = 0;
      int  got  = 0;
      int  cyc  = 0;
      logic acc, xf;
      out_ready = 1'b1;
      while (got < n && cyc < 4 * n + 20) begin
         step();
         in_valid = (sent < n);
         p0 = 16'(64 * ((sent * 7) % 256));
         p1 = 16'sd0; p2 = 16'sd0; p3 = 16'sd0;
         #1;
         acc = in_valid & in_ready;
         xf  = out_valid & out_ready;
         if (xf) begin
            chk({tag, " pix"}, out_pix, 32'((got * 7) % 256));
            chk({tag, " last"}, out_last, 32'(got % 16 == 15));
            got++;
         end
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      chk({tag, " count"}, got, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int sent, got, cyc;
      logic acc, xf;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      p0 = 16'sd0; p1 = 16'sd0; p2 = 16'sd0; p3 = 16'sd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst out_pix", out_pix, 0);
      chk("rst out_last", out_last, 0);
      chk("rst clip_flag", clip_flag, 0);
      chk("rst in_ready", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("rel in_ready_early", in_ready, 0);
      step();
      chk("rel in_ready", in_ready, 1);

      // Basic sum, rounding boundaries and both clip directions.
      send_one(-16'sd100, 16'sd3200, 16'sd3400, -16'sd100, 8'd100, 1'b0, "basic");
      send_one(16'sd31, 16'sd0, 16'sd0, 16'sd0, 8'd0, 1'b0, "rnd31");
      send_one(16'sd32, 16'sd0, 16'sd0, 16'sd0, 8'd1, 1'b0, "rnd32");
      send_one(16'sd95, 16'sd0, 16'sd0, 16'sd0, 8'd1, 1'b0, "rnd95");
      send_one(16'sd96, 16'sd0, 16'sd0, 16'sd0, 8'd2, 1'b0, "rnd96");
      send_one(16'sd0, 16'sd20000, 16'sd0, 16'sd0, 8'd255, 1'b1, "clip_hi");
      send_one(-16'sd3825, 16'sd0, 16'sd0, 16'sd0, 8'd0, 1'b1, "clip_lo");

      // Back-pressure: five inputs, consumer stalls in cycles 3..6; sample k yields 10+k.
      step();
      sent = 0; got = 0; cyc = 0;
      while (got < 5 && cyc < 40) begin
         in_valid  = (sent < 5);
         p0 = 16'(64 * (10 + sent));
         p1 = 16'sd0; p2 = 16'sd0; p3 = 16'sd0;
         out_ready = !(cyc >= 3 && cyc <= 6);
         #1;
         if (sent < 5) chk("bp in_ready", in_ready, 32'(!(cyc >= 3 && cyc <= 6)));
         if (cyc >= 3 && cyc <= 6) begin
            chk("bp hold_valid", out_valid, 1);
            chk("bp hold_pix", out_pix, 11);
         end
         acc = in_valid & in_ready;
         xf  = out_valid & out_ready;
         if (xf) begin
            chk("bp order", out_pix, 32'(10 + got));
            got++;
         end
         if (acc) sent++;
         cyc++;
         step();
      end
      in_valid = 1'b0;
      chk("bp count", got, 5);

      // Fresh block: out_last on the 16th and 32nd transfers.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      stream(32, "blk32");

      // Mid-block reset with both stages full.
      stream(5, "pre");
      step();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      p0 = 16'(64 * 200);
      repeat (3) step();
      chk("full out_valid", out_valid, 1);
      chk("full in_ready", in_ready, 0);
      chk("full pix", out_pix, 200);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst out_valid", out_valid, 0);
      chk("mid_rst out_pix", out_pix, 0);
      chk("mid_rst out_last", out_last, 0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      stream(16, "post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
